// File: rtl/bloom_ctrl.sv
// bloom_ctrl: arbitrates insert/query requests onto a bloom_filter and manages its clears.
// Latency: insert strobe 1 cycle after handshake; query response QRY_LAT+2 cycles after handshake.
// Backpressure: ins_ready/qry_ready drop whenever busy or a clear is pending; requests simply wait.
module bloom_ctrl #(
  parameter int DATA_W  = 32,
  parameter int QRY_LAT = 1,
  parameter int MAX_INS = 64,
  parameter int CLR_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ins_valid,
  input  logic [DATA_W-1:0] ins_data,
  output logic              ins_ready,
  input  logic              qry_valid,
  input  logic [DATA_W-1:0] qry_data,
  output logic              qry_ready,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              clr_req,
  output logic              bf_rstn,
  output logic              bf_insert_valid,
  output logic [DATA_W-1:0] bf_insert_data,
  output logic              bf_query_valid,
  output logic [DATA_W-1:0] bf_query_data,
  input  logic              bf_query_result,
  output logic [15:0]       ins_count,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, INSERT, QUERY, WAIT, CLEAR} state_t;

  // Last WAIT count (result sampling point) and last CLEAR count.
  localparam logic [3:0]  RSP_CNT = 4'(QRY_LAT - 1);
  localparam logic [3:0]  CLR_END = 4'(CLR_CYC - 1);
  localparam logic [15:0] MAX_CNT = 16'(MAX_INS);

  state_t      state, state_nxt;
  logic        rr_ptr;       // 0: insert wins a tie, 1: query wins a tie
  logic        clr_pending;
  logic [3:0]  cnt;          // cycles spent in the current WAIT/CLEAR state
  logic        idle_ok, ins_sel, ins_acc, qry_acc;
  logic        rsp_take, clr_done;
  logic [15:0] cnt_inc;

  // Handshake arbitration: readies only in a clean IDLE, one winner at a time.
  always_comb begin
    idle_ok   = !rst && (state == IDLE) && !clr_pending;
    ins_sel   = !(qry_valid && (!ins_valid || rr_ptr));
    ins_ready = idle_ok && ins_sel;
    qry_ready = idle_ok && !ins_sel;
    ins_acc   = ins_ready && ins_valid;
    qry_acc   = qry_ready && qry_valid;
    busy      = !rst && (state != IDLE);
    rsp_take  = (state == WAIT) && (cnt == RSP_CNT);
    clr_done  = (state == CLEAR) && (cnt == CLR_END);
    cnt_inc   = (ins_count == 16'hFFFF) ? ins_count : ins_count + 16'd1;
  end

  // Next-state logic; a pending clear outranks both requesters in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (clr_pending)  state_nxt = CLEAR;
        else if (ins_acc) state_nxt = INSERT;
        else if (qry_acc) state_nxt = QUERY;
      end
      INSERT:  state_nxt = IDLE;
      QUERY:   state_nxt = WAIT;
      WAIT:    if (rsp_take) state_nxt = IDLE;
      CLEAR:   if (clr_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register and per-state cycle counter (restarts on every state change).
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 4'd0 : cnt + 4'd1;
    end
  end

  // Arbitration pointer, insert counter and clear bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= 1'b0;
      ins_count   <= '0;
      clr_pending <= 1'b0;
    end else begin
      if (ins_valid && qry_valid && (ins_acc || qry_acc))
        rr_ptr <= ~rr_ptr;
      if (clr_done)
        ins_count <= '0;
      else if (ins_acc)
        ins_count <= cnt_inc;
      // Requests seen during CLEAR are absorbed; manual and auto requests merge into one flag.
      if (clr_done)
        clr_pending <= 1'b0;
      else if ((clr_req && state != CLEAR) || (ins_acc && cnt_inc == MAX_CNT))
        clr_pending <= 1'b1;
    end
  end

  // Filter-side strobes, held keys, response and the filter reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bf_insert_valid <= 1'b0;
      bf_insert_data  <= '0;
      bf_query_valid  <= 1'b0;
      bf_query_data   <= '0;
      rsp_valid       <= 1'b0;
      rsp_hit         <= 1'b0;
      rsp_data        <= '0;
      bf_rstn         <= 1'b0;
    end else begin
      bf_insert_valid <= ins_acc;
      bf_query_valid  <= qry_acc;
      if (ins_acc) bf_insert_data <= ins_data;
      if (qry_acc) bf_query_data  <= qry_data;
      rsp_valid <= rsp_take;
      if (rsp_take) begin
        rsp_hit  <= bf_query_result;
        rsp_data <= bf_query_data;
      end
      bf_rstn <= (state_nxt != CLEAR);
    end
  end

endmodule

// File: tb/tb_bloom_ctrl.sv
// Directed bench for bloom_ctrl with a behavioural exact-match filter and a response scoreboard.
module tb_bloom_ctrl;
  localparam int DW = 32;
  localparam int QL = 1;
  localparam int MI = 3;
  localparam int CC = 4;

  logic          clk = 1'b0;
  logic          rst, ins_valid, qry_valid, clr_req;
  logic [DW-1:0] ins_data, qry_data;
  logic          ins_ready, qry_ready, rsp_valid, rsp_hit, bf_rstn;
  logic          bf_insert_valid, bf_query_valid, busy;
  logic          bf_query_result = 1'b0;
  logic [DW-1:0] rsp_data, bf_insert_data, bf_query_data;
  logic [15:0]   ins_count;

  always #5 clk = ~clk;

  bloom_ctrl #(.DATA_W(DW), .QRY_LAT(QL), .MAX_INS(MI), .CLR_CYC(CC)) dut (
    .clk(clk), .rst(rst),
    .ins_valid(ins_valid), .ins_data(ins_data), .ins_ready(ins_ready),
    .qry_valid(qry_valid), .qry_data(qry_data), .qry_ready(qry_ready),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_data(rsp_data),
    .clr_req(clr_req), .bf_rstn(bf_rstn),
    .bf_insert_valid(bf_insert_valid), .bf_insert_data(bf_insert_data),
    .bf_query_valid(bf_query_valid), .bf_query_data(bf_query_data),
    .bf_query_result(bf_query_result),
    .ins_count(ins_count), .busy(busy)
  );

  // Exact-membership stand-in for the bloom filter, one-cycle query latency.
  logic [DW-1:0] fkeys[$];
  always @(posedge clk) begin : filt
    logic hit;
    hit = 1'b0;
    foreach (fkeys[i]) if (fkeys[i] == bf_query_data) hit = 1'b1;
    if (bf_query_valid === 1'b1) bf_query_result <= hit;
    if (bf_rstn !== 1'b1) fkeys.delete();
    else if (bf_insert_valid === 1'b1) fkeys.push_back(bf_insert_data);
  end

  typedef struct { logic hit; logic [DW-1:0] data; } exp_t;
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Response scoreboard and mutual-exclusion checks.
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      check("ready_excl", {63'd0, ins_ready & qry_ready}, 64'd0);
      check("strobe_excl", {63'd0, bf_insert_valid & bf_query_valid}, 64'd0);
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) check("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
        else begin
          e = exp_q.pop_front();
          check("rsp_hit", {63'd0, rsp_hit}, {63'd0, e.hit});
          check("rsp_data", {32'd0, rsp_data}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    rst = 1'b1; ins_valid = 1'b0; qry_valid = 1'b0; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic do_ins(input logic [DW-1:0] k, input logic with_clr);
    int n;
    n = 0;
    @(negedge clk); ins_valid = 1'b1; ins_data = k; #1;
    while (ins_ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) check("ins_timeout", {63'd0, ins_ready}, 64'd1);
    if (with_clr) clr_req = 1'b1;
    @(posedge clk); #1;
    ins_valid = 1'b0; clr_req = 1'b0;
    check("ins_strobe", {63'd0, bf_insert_valid}, 64'd1);
    check("ins_key", {32'd0, bf_insert_data}, {32'd0, k});
  endtask

  task automatic do_qry(input logic [DW-1:0] k, input logic hit, input logic clr_wait);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk); qry_valid = 1'b1; qry_data = k; #1;
    while (qry_ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) check("qry_timeout", {63'd0, qry_ready}, 64'd1);
    e.hit = hit; e.data = k;
    exp_q.push_back(e);
    @(posedge clk); #1; qry_valid = 1'b0;                       // T+1
    check("qry_strobe", {63'd0, bf_query_valid}, 64'd1);
    check("qry_key", {32'd0, bf_query_data}, {32'd0, k});
    @(posedge clk); #1;                                          // T+2
    check("qry_rsp_early", {63'd0, rsp_valid}, 64'd0);
    check("qry_busy_wait", {63'd0, busy}, 64'd1);
    if (clr_wait) clr_req = 1'b1;
    @(posedge clk); #1; clr_req = 1'b0;                          // T+3
    check("qry_rsp_lat", {63'd0, rsp_valid}, 64'd1);
    check("qry_idle_after", {63'd0, busy}, 64'd0);
    if (clr_wait) begin
      check("clr_blocks_ready", {63'd0, ins_ready}, 64'd0);
      @(posedge clk); #1;                                        // T+4
      check("clr_enter_busy", {63'd0, busy}, 64'd1);
      check("clr_enter_rstn", {63'd0, bf_rstn}, 64'd0);
    end
  endtask

  task automatic measure_clear(output int low, output int falls);
    logic prev;
    low = 0; falls = 0; prev = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bf_rstn === 1'b0) begin
        low++;
        check("clr_busy", {63'd0, busy}, 64'd1);
        if (prev === 1'b1) falls++;
      end
      prev = bf_rstn;
    end
  endtask

  localparam logic [DW-1:0] K0 = 32'hc0a9011e;
  localparam logic [DW-1:0] K1 = 32'h11112222;
  localparam logic [DW-1:0] K2 = 32'h33334444;
  localparam logic [DW-1:0] K3 = 32'h55556666;

  initial begin
    logic g[4];
    int   grants, n, low, falls;
    ins_data = '0; qry_data = '0;

    // Reset values while rst is held.
    do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_ins_ready", {63'd0, ins_ready}, 64'd0);
    check("rst_qry_ready", {63'd0, qry_ready}, 64'd0);
    check("rst_bf_rstn", {63'd0, bf_rstn}, 64'd0);
    check("rst_ins_count", {48'd0, ins_count}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_bf_qdata", {32'd0, bf_query_data}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_bf_rstn", {63'd0, bf_rstn}, 64'd1);
    mon_en = 1'b1;

    // Insert then query the same key.
    do_ins(K0, 1'b0);
    check("ins_count_1", {48'd0, ins_count}, 64'd1);
    do_qry(K0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);

    // Both requesters held from reset: alternating grants.
    rst = 1'b1; ins_valid = 1'b1; qry_valid = 1'b1; clr_req = 1'b0;
    ins_data = K1; qry_data = K1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    grants = 0; n = 0;
    while (grants < 4 && n < 200) begin
      @(negedge clk);
      if (ins_ready === 1'b1) begin
        g[grants] = 1'b0; grants++;
      end else if (qry_ready === 1'b1) begin
        exp_t e;
        e.hit = 1'b1; e.data = K1;
        exp_q.push_back(e);
        g[grants] = 1'b1; grants++;
      end
      if (grants == 4) begin @(posedge clk); #1; ins_valid = 1'b0; qry_valid = 1'b0; end
      n++;
    end
    check("rr_grant_count", 64'(grants), 64'd4);
    check("rr_grant0", {63'd0, g[0]}, 64'd0);
    check("rr_grant1", {63'd0, g[1]}, 64'd1);
    check("rr_grant2", {63'd0, g[2]}, 64'd0);
    check("rr_grant3", {63'd0, g[3]}, 64'd1);
    repeat (6) @(posedge clk);
    #1 check("rr_ins_count", {48'd0, ins_count}, 64'd2);

    // Auto-clear after MAX_INS inserts.
    do_reset();
    do_ins(K1, 1'b0);
    do_ins(K2, 1'b0);
    do_ins(K3, 1'b0);
    check("auto_ins_count", {48'd0, ins_count}, 64'd3);
    check("auto_busy", {63'd0, busy}, 64'd1);
    measure_clear(low, falls);
    check("auto_low_cycles", 64'(low), 64'd4);
    check("auto_pulses", 64'(falls), 64'd1);
    check("auto_count_zero", {48'd0, ins_count}, 64'd0);
    do_qry(K1, 1'b0, 1'b0);

    // Software clear during WAIT: response first, then clear.
    do_reset();
    do_ins(K0, 1'b0);
    do_qry(K0, 1'b1, 1'b1);
    measure_clear(low, falls);
    check("wclr_low_cycles", 64'(low), 64'd4);
    check("wclr_pulses", 64'(falls), 64'd1);
    check("wclr_count_zero", {48'd0, ins_count}, 64'd0);

    // Software clear coinciding with auto-clear: single pulse.
    do_reset();
    do_ins(K1, 1'b0);
    do_ins(K2, 1'b0);
    do_ins(K3, 1'b1);
    measure_clear(low, falls);
    check("dual_low_cycles", 64'(low), 64'd4);
    check("dual_pulses", 64'(falls), 64'd1);

    // Reset mid-query discards the response.
    do_reset();
    do_ins(K0, 1'b0);
    n = 0;
    @(negedge clk); qry_valid = 1'b1; qry_data = K0; #1;
    while (qry_ready !== 1'b1 && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) check("mrst_timeout", {63'd0, qry_ready}, 64'd1);
    @(posedge clk); #1; qry_valid = 1'b0;                        // T+1
    @(posedge clk); #1; rst = 1'b1; #1;                          // T+2
    check("mrst_ins_ready", {63'd0, ins_ready}, 64'd0);
    check("mrst_qry_ready", {63'd0, qry_ready}, 64'd0);
    check("mrst_busy_in", {63'd0, busy}, 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    check("mrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_bf_rstn", {63'd0, bf_rstn}, 64'd0);
    check("mrst_count", {48'd0, ins_count}, 64'd0);
    check("mrst_qvalid", {63'd0, bf_query_valid}, 64'd0);
    check("mrst_qdata", {32'd0, bf_query_data}, 64'd0);
    check("mrst_idata", {32'd0, bf_insert_data}, 64'd0);
    check("mrst_rsp_data", {32'd0, rsp_data}, 64'd0);
    check("mrst_rsp_hit", {63'd0, rsp_hit}, 64'd0);
    @(posedge clk); #1;
    check("mrst_rel_rstn", {63'd0, bf_rstn}, 64'd1);
    repeat (8) @(posedge clk);

    #1 check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bloom_ctrl.md
BLOOM_CTRL -- requirements
Module: bloom_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: key width, equal to the bloom_filter data width.
REQ-002 The block SHALL have parameter QRY_LAT, default 1: cycles from bf_query_valid to a valid bf_query_result (range 1-7).
REQ-003 The block SHALL have parameter MAX_INS, default 64: number of inserts that triggers an automatic clear (range 1-65535).
REQ-004 The block SHALL have parameter CLR_CYC, default 4: number of cycles bf_rstn is held low per clear (range 1-15).
REQ-005 The block SHALL have one clock and a synchronous active-high reset.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ins_valid  in  1  insert request.
- ins_data  in  DATA_W  key to insert.
- ins_ready  out  1  insert accepted when ins_valid&ins_ready.
- qry_valid  in  1  query request.
- qry_data  in  DATA_W  key to query.
- qry_ready  out  1  query accepted when qry_valid&qry_ready.
- rsp_valid  out  1  one-cycle query response strobe.
- rsp_hit  out  1  query result, valid with rsp_valid.
- rsp_data  out  DATA_W  echo of the queried key.
- clr_req  in  1  single-cycle software clear request.
- bf_rstn  out  1  active-low reset to bloom_filter.
- bf_insert_valid  out  1  bloom_filter insert strobe.
- bf_insert_data  out  DATA_W  bloom_filter insert key.
- bf_query_valid  out  1  bloom_filter query strobe.
- bf_query_data  out  DATA_W  bloom_filter query key.
- bf_query_result  in  1  bloom_filter hit result.
- ins_count  out  16  inserts since last clear.
- busy  out  1  high in any state other than IDLE.

Function
REQ-007 The FSM SHALL have states IDLE, INSERT, QUERY, WAIT and CLEAR.
REQ-008 The ready outputs SHALL be combinational and high only in IDLE with no pending clear; at most one of ins_ready and qry_ready SHALL be high in any cycle.
REQ-009 When both requests are valid in IDLE, the block SHALL grant round-robin: rr_ptr selects the winner, then toggles to the loser; when only one request is valid it is granted and rr_ptr is unchanged.
REQ-010 An insert accepted at cycle T SHALL go IDLE->INSERT, with bf_insert_valid=1 and bf_insert_data=key during T+1 only, and ins_count incremented at T+1.
REQ-011 A query accepted at cycle T SHALL go IDLE->QUERY->WAIT, with bf_query_valid=1 and bf_query_data=key during T+1 only.
REQ-012 For a query, the block SHALL sample bf_query_result at T+1+QRY_LAT and assert rsp_valid=1 for exactly one cycle at T+2+QRY_LAT, with rsp_hit and rsp_data set; the FSM SHALL then return to IDLE.
REQ-013 bf_query_data and bf_insert_data SHALL hold their last value when not strobed; the strobes SHALL never be high simultaneously.
REQ-014 A clr_req pulse SHALL set a clr_pending flag in any state; an in-flight INSERT or QUERY/WAIT SHALL complete first, including the response.
REQ-015 In IDLE, clr_pending SHALL take priority over both requesters.
REQ-016 ins_count reaching MAX_INS after an insert SHALL set clr_pending (auto-clear).
REQ-017 An auto-clear and a clr_req arriving together SHALL produce a single clear.
REQ-018 CLEAR SHALL drive bf_rstn=0 for exactly CLR_CYC cycles, clear ins_count to 0 and clr_pending, then return to IDLE with bf_rstn=1.
REQ-019 A clr_req arriving during CLEAR SHALL be absorbed and SHALL NOT cause a second clear.
REQ-020 ins_count SHALL saturate at 0xFFFF and never wrap.
REQ-021 Requests SHALL remain pending without any ready while busy=1; the block SHALL drop no request and require no data hold beyond the handshake.

Reset
REQ-022 While rst=1, the block SHALL force: state=IDLE, rr_ptr=insert-first, clr_pending=0, ins_count=0, all strobes, readies, rsp_hit and busy=0, rsp_data=0, bf_*_data=0, bf_rstn=0.
REQ-023 In the cycle after rst falls, the block SHALL drive bf_rstn=1.
REQ-024 A reset asserted mid-query SHALL discard the in-flight query, with no rsp_valid after reset.

Verification
REQ-025 The bench SHALL cover: reset, insert 0xc0a9011e, query 0xc0a9011e with QRY_LAT=1 -> bf_query_valid at T+1, rsp_valid at T+3, rsp_hit=1, rsp_data=0xc0a9011e, ins_count=1.
REQ-026 The bench SHALL cover: ins_valid and qry_valid held together from reset for 4 grants -> grant order insert, query, insert, query, never both readies high.
REQ-027 The bench SHALL cover: MAX_INS=3, three inserts -> after the third, busy=1 and bf_rstn=0 for exactly 4 cycles, then ins_count=0; a query of the first key after the clear -> rsp_hit=0 (with the real filter).
REQ-028 The bench SHALL cover: clr_req pulsed during WAIT -> response still delivered, then CLEAR entered the next IDLE cycle; clr_req plus auto-clear in the same cycle -> exactly one CLR_CYC-cycle bf_rstn pulse.
REQ-029 The bench SHALL cover: rst asserted for 1 cycle at T+2 of a query -> no rsp_valid, outputs at reset values, bf_rstn=1 one cycle after release.
